branch_predict_unit: RTL and testbench

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

---
 rtl/branch_predict_unit_pkg.sv | 29 ++
 rtl/branch_predict_unit_if.sv | 32 +++
 rtl/branch_predict_unit_cond.sv | 28 ++
 rtl/branch_predict_unit.sv | 84 ++++++++
 tb/tb_branch_predict_unit.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/branch_predict_unit_pkg.sv
// Shared encodings for the branch predictor: branch condition codes,
// redirect decisions and 2-bit saturating counter states.
package branch_predict_unit_pkg;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  typedef enum logic [1:0] {
    DEC_SEQ = 2'b00,
    DEC_IMM = 2'b01,
    DEC_REG = 2'b10
  } decision_t;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Saturating 2-bit counter step toward the resolved outcome.
  function automatic logic [1:0] ctr_update(input logic [1:0] c, input logic taken);
    if (taken) return (c == ST)  ? ST  : c + 2'd1;
    else       return (c == SNT) ? SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Fetch-lookup and EX-resolve signal bundle of the branch predictor.
interface branch_predict_unit_if #(
  parameter int XLEN = 32
);
  logic            f_valid;
  logic [XLEN-1:0] f_pc;
  logic            f_pred_taken;

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic            r_branch;
  logic            r_jal;
  logic            r_jalr;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_data1;
  logic [XLEN-1:0] r_data2;
  logic            r_pred_taken;
  logic [1:0]      r_decision;
  logic            r_mispredict;

  modport master (
    output f_valid, f_pc, r_valid, r_pc, r_branch, r_jal, r_jalr,
           r_funct3, r_data1, r_data2, r_pred_taken,
    input  f_pred_taken, r_decision, r_mispredict
  );

  modport slave (
    input  f_valid, f_pc, r_valid, r_pc, r_branch, r_jal, r_jalr,
           r_funct3, r_data1, r_data2, r_pred_taken,
    output f_pred_taken, r_decision, r_mispredict
  );
endinterface

// File: rtl/branch_predict_unit_cond.sv
// Branch condition evaluator: resolves funct3 against two operands.
module br_cond_eval
  import branch_predict_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  output logic            cond,
  output logic            legal
);

  always_comb begin
    cond  = 1'b0;
    legal = 1'b1;
    case (funct3)
      BR_BEQ:  cond = (data1 == data2);
      BR_BNE:  cond = (data1 != data2);
      BR_BLT:  cond = ($signed(data1) <  $signed(data2));
      BR_BGE:  cond = ($signed(data1) >= $signed(data2));
      BR_BLTU: cond = (data1 <  data2);
      BR_BGEU: cond = (data1 >= data2);
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor: flop-array BHT of 2-bit counters, EX-stage
// resolution with mispredict redirect, and saturating perf counters.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 16,
  parameter int PERF_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  branch_predict_unit_if.slave bus,
  output logic               flush_q,
  output logic [PERF_W-1:0]  br_count,
  output logic [PERF_W-1:0]  mispred_count
);

  localparam int IW = $clog2(BHT_DEPTH);

  logic [1:0]    bht [BHT_DEPTH];
  logic [IW-1:0] f_idx;
  logic [IW-1:0] r_idx;
  logic          cond;
  logic          legal;
  logic          branch_only;
  logic          bht_we;
  logic          mispredict;
  decision_t     decision;
  logic          unused_pc_bits;

  assign f_idx = bus.f_pc[IW+1:2];
  assign r_idx = bus.r_pc[IW+1:2];
  assign unused_pc_bits = ^{bus.f_pc[XLEN-1:IW+2], bus.f_pc[1:0],
                            bus.r_pc[XLEN-1:IW+2], bus.r_pc[1:0]};

  br_cond_eval #(.XLEN(XLEN)) u_cond (
    .funct3 (bus.r_funct3),
    .data1  (bus.r_data1),
    .data2  (bus.r_data2),
    .cond   (cond),
    .legal  (legal)
  );

  // A jump class sharing the slot with r_branch overrides it entirely.
  assign branch_only = bus.r_valid & bus.r_branch & ~bus.r_jal & ~bus.r_jalr;
  assign bht_we      = branch_only & legal;
  assign mispredict  = branch_only & (cond != bus.r_pred_taken);

  always_comb begin
    decision = DEC_SEQ;
    if (bus.r_valid) begin
      if (bus.r_jalr)        decision = DEC_REG;
      else if (bus.r_jal)    decision = DEC_IMM;
      else if (bus.r_branch) decision = cond ? DEC_IMM : DEC_SEQ;
    end
  end

  assign bus.r_decision   = decision;
  assign bus.r_mispredict = mispredict;
  assign bus.f_pred_taken = bus.f_valid & bht[f_idx][1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= WNT;
    end else if (bht_we) begin
      bht[r_idx] <= ctr_update(bht[r_idx], cond);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_q       <= 1'b0;
      br_count      <= '0;
      mispred_count <= '0;
    end else begin
      flush_q <= mispredict;
      if (bht_we && (br_count != '1))
        br_count <= br_count + PERF_W'(1);
      if (mispredict && (mispred_count != '1))
        mispred_count <= mispred_count + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed and randomized check of branch_predict_unit against a behavioural model.
module tb_branch_predict_unit;
  import branch_predict_unit_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst2;
  logic        flush_q, flush_q2;
  logic [31:0] br_count, mispred_count;
  logic [3:0]  br_count2, mispred_count2;

  branch_predict_unit_if #(.XLEN(32)) bus  ();
  branch_predict_unit_if #(.XLEN(32)) bus2 ();

  branch_predict_unit #(.XLEN(32), .BHT_DEPTH(16), .PERF_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .flush_q(flush_q), .br_count(br_count), .mispred_count(mispred_count)
  );

  branch_predict_unit #(.XLEN(32), .BHT_DEPTH(4), .PERF_W(4)) dut2 (
    .clk(clk), .rst(rst2), .bus(bus2),
    .flush_q(flush_q2), .br_count(br_count2), .mispred_count(mispred_count2)
  );

  int total = 0;
  int bad   = 0;

  int  bht_m [16];
  int  br_m, mis_m;
  bit  flush_m;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_cond(input bit [2:0] f, input bit [31:0] a, input bit [31:0] b);
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) <  $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a <  b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int idx16(input bit [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  // One resolve/lookup cycle on the main DUT, with model update and checks.
  task automatic step(input bit v, input bit [31:0] pc, input bit br, input bit jal,
                      input bit jalr, input bit [2:0] f3, input bit [31:0] d1,
                      input bit [31:0] d2, input bit pt, input bit fv, input bit [31:0] fpc);
    bit c, lg, only_br, exp_mis, exp_fpt;
    int exp_dec;
    @(negedge clk);
    bus.r_valid = v;  bus.r_pc = pc;  bus.r_branch = br;  bus.r_jal = jal;
    bus.r_jalr = jalr; bus.r_funct3 = f3; bus.r_data1 = d1; bus.r_data2 = d2;
    bus.r_pred_taken = pt; bus.f_valid = fv; bus.f_pc = fpc;
    #1;
    c       = ref_cond(f3, d1, d2);
    lg      = (f3 != 3'd2) && (f3 != 3'd3);
    only_br = v && br && !jal && !jalr;
    exp_mis = only_br && (c != pt);
    exp_fpt = fv && (bht_m[idx16(fpc)] >= 2);
    if (!v)        exp_dec = 0;
    else if (jalr) exp_dec = 2;
    else if (jal)  exp_dec = 1;
    else if (br)   exp_dec = c ? 1 : 0;
    else           exp_dec = 0;
    check("decision", 64'(bus.r_decision), 64'(exp_dec));
    check("mispredict", 64'(bus.r_mispredict), 64'(exp_mis));
    check("f_pred_taken", 64'(bus.f_pred_taken), 64'(exp_fpt));
    @(posedge clk);
    #1;
    if (only_br && lg) begin
      if (c) bht_m[idx16(pc)] = (bht_m[idx16(pc)] == 3) ? 3 : bht_m[idx16(pc)] + 1;
      else   bht_m[idx16(pc)] = (bht_m[idx16(pc)] == 0) ? 0 : bht_m[idx16(pc)] - 1;
      br_m++;
    end
    if (exp_mis) mis_m++;
    flush_m = exp_mis;
    check("flush_q", 64'(flush_q), 64'(flush_m));
    check("br_count", 64'(br_count), 64'(br_m));
    check("mispred_count", 64'(mispred_count), 64'(mis_m));
  endtask

  initial begin
    bit [31:0] pc, d1, d2;
    int k;
    bus.f_valid = 0; bus.f_pc = 0; bus.r_valid = 0; bus.r_pc = 0; bus.r_branch = 0;
    bus.r_jal = 0; bus.r_jalr = 0; bus.r_funct3 = 0; bus.r_data1 = 0; bus.r_data2 = 0;
    bus.r_pred_taken = 0;
    bus2.f_valid = 0; bus2.f_pc = 0; bus2.r_valid = 0; bus2.r_pc = 0; bus2.r_branch = 0;
    bus2.r_jal = 0; bus2.r_jalr = 0; bus2.r_funct3 = 0; bus2.r_data1 = 0; bus2.r_data2 = 0;
    bus2.r_pred_taken = 0;
    rst = 1; rst2 = 1;
    for (int i = 0; i < 16; i++) bht_m[i] = 1;
    br_m = 0; mis_m = 0; flush_m = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0; rst2 = 0;

    // Reset state
    bus.f_valid = 1; bus.f_pc = 32'h40;
    #1;
    check("rst_f_pred", 64'(bus.f_pred_taken), 64'(0));
    check("rst_br_count", 64'(br_count), 64'(0));
    check("rst_mispred_count", 64'(mispred_count), 64'(0));
    check("rst_flush_q", 64'(flush_q), 64'(0));

    // Signed BLT taken, predicted not taken
    step(1, 32'h108, 1, 0, 0, BR_BLT, 32'hFFFF_FFFF, 32'h1, 0, 1, 32'h40);
    check("blt_flush_const", 64'(flush_q), 64'(1));
    check("blt_mis_const", 64'(mispred_count), 64'(1));

    // Unsigned BLTU not taken: counter 01 -> 00, then two takens needed to flip MSB
    step(1, 32'h4C, 1, 0, 0, BR_BLTU, 32'hFFFF_FFFF, 32'h1, 0, 0, 32'h0);
    step(1, 32'h4C, 1, 0, 0, BR_BEQ, 32'h5, 32'h5, 1, 1, 32'h4C);
    step(1, 32'h4C, 1, 0, 0, BR_BEQ, 32'h5, 32'h5, 1, 1, 32'h4C);
    step(0, 32'h0, 0, 0, 0, BR_BEQ, 32'h0, 32'h0, 0, 1, 32'h4C);
    check("bltu_dec_path_msb", 64'(bus.f_pred_taken), 64'(1));

    // Five taken BEQ at 0x80 with same-cycle lookup
    for (int i = 0; i < 5; i++)
      step(1, 32'h80, 1, 0, 0, BR_BEQ, 32'h1234, 32'h1234, 1, 1, 32'h80);
    step(0, 32'h0, 0, 0, 0, BR_BEQ, 32'h0, 32'h0, 0, 1, 32'h80);
    check("beq_lookup_const", 64'(bus.f_pred_taken), 64'(1));

    // JALR overrides a simultaneous r_branch
    step(1, 32'h84, 1, 0, 1, BR_BEQ, 32'h7, 32'h7, 0, 0, 32'h0);
    check("jalr_dec_const", 64'(flush_q), 64'(0));

    // Illegal funct3 and JAL
    step(1, 32'h90, 1, 0, 0, 3'b010, 32'h1, 32'h1, 1, 1, 32'h90);
    step(1, 32'h94, 0, 1, 0, BR_BNE, 32'h1, 32'h2, 0, 1, 32'h94);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      pc = $urandom & 32'h7C;
      d1 = $urandom;
      d2 = ($urandom_range(0, 3) == 0) ? d1 : $urandom;
      if ($urandom_range(0, 3) == 0) begin d1 = d1 & 32'hF; d2 = d2 & 32'hF; end
      k = $urandom_range(0, 7);
      step($urandom_range(0, 7) != 0, pc,
           (k == 1) || (k == 2) || (k == 3) || (k == 6) || (k == 7),
           (k == 4) || (k == 6) || (k == 7),
           (k == 5) || (k == 7),
           3'($urandom_range(0, 7)), d1, d2, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? pc : ($urandom & 32'h7C));
    end

    // Small DUT: 4-bit counters saturate, then mid-stream reset
    @(negedge clk);
    bus2.r_valid = 1; bus2.r_pc = 32'h10; bus2.r_branch = 1; bus2.r_funct3 = BR_BEQ;
    bus2.r_data1 = 32'h3; bus2.r_data2 = 32'h3; bus2.r_pred_taken = 0;
    bus2.f_valid = 1; bus2.f_pc = 32'h10;
    repeat (3) @(posedge clk);
    #1;
    check("small_mis_3", 64'(mispred_count2), 64'(3));
    repeat (17) @(posedge clk);
    #1;
    check("small_mis_sat", 64'(mispred_count2), 64'(4'hF));
    check("small_br_sat", 64'(br_count2), 64'(4'hF));
    check("small_lookup", 64'(bus2.f_pred_taken), 64'(1));
    check("small_flush", 64'(flush_q2), 64'(1));
    @(negedge clk);
    #2;
    rst2 = 1;
    #1;
    check("rst_mid_mis", 64'(mispred_count2), 64'(0));
    check("rst_mid_br", 64'(br_count2), 64'(0));
    check("rst_mid_flush", 64'(flush_q2), 64'(0));
    check("rst_mid_fpred", 64'(bus2.f_pred_taken), 64'(0));
    check("rst_mid_comb_mis", 64'(bus2.r_mispredict), 64'(1));
    check("rst_mid_comb_dec", 64'(bus2.r_decision), 64'(1));
    @(posedge clk);
    #1;
    check("rst_hold_mis", 64'(mispred_count2), 64'(0));
    @(negedge clk);
    rst2 = 0;
    bus2.r_valid = 0;
    #1;
    check("post_rst_lookup", 64'(bus2.f_pred_taken), 64'(0));
    @(posedge clk);
    #1;
    check("post_rst_flush", 64'(flush_q2), 64'(0));
    check("post_rst_br", 64'(br_count2), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
